// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe turn controller.
package ttt_pkg;

    typedef logic [1:0] cell_t;

    localparam cell_t CELL_EMPTY = 2'b00;
    localparam cell_t CELL_P0    = 2'b10;
    localparam cell_t CELL_P1    = 2'b11;

    localparam int BOARD_CELLS = 9;

    typedef logic [BOARD_CELLS-1:0][1:0] board_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_MOVE,
        CHECK,
        GAME_OVER
    } state_t;

endpackage

// File: rtl/ttt_turn_timer.sv
// Per-turn countdown: a prescaler ticking seconds and a seconds down-counter
// that raises a one-cycle timeout when the last second elapses.
module ttt_turn_timer #(
    parameter int CYCLES_PER_SEC = 50_000_000,
    parameter int TURN_SECONDS   = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       reload,
    input  logic       enable,
    output logic [3:0] secs_left,
    output logic       timeout
);

    localparam int PRE_W = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(CYCLES_PER_SEC - 1);
    localparam logic [3:0]       SECS_INIT = 4'(TURN_SECONDS);

    logic [PRE_W-1:0] presc;
    logic [3:0]       secs;
    logic             wrap;

    assign wrap      = enable && (presc == PRE_MAX);
    assign timeout   = wrap && (secs == 4'd1);
    assign secs_left = secs;

    // The counter holds at 1 on timeout; the controller reloads it afterwards.
    always_ff @(posedge clk) begin
        if (rst || reload) begin
            presc <= '0;
            secs  <= SECS_INIT;
        end else if (enable) begin
            if (wrap) begin
                presc <= '0;
                if (secs > 4'd1) secs <= secs - 4'd1;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ttt_turn_controller.sv
// Tic-tac-toe turn controller: owns the board, alternates players, auto-plays
// on turn timeout and latches the result reported by the end detector.
module ttt_turn_controller
    import ttt_pkg::*;
#(
    parameter int CYCLES_PER_SEC = 50_000_000,
    parameter int TURN_SECONDS   = 10
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            move_valid_i,
    input  logic [3:0]      move_pos_i,
    input  logic            game_end_i,
    input  logic            tie_i,
    input  logic            winner_i,
    output logic [8:0][1:0] board_o,
    output logic            player_o,
    output logic            move_ack_o,
    output logic            move_reject_o,
    output logic            auto_move_o,
    output logic [3:0]      secs_left_o,
    output logic            game_over_o,
    output logic            tie_o,
    output logic            winner_o
);

    state_t state_q, state_n;
    board_t board_q, board_n;
    logic   player_q, player_n;
    logic   ack_q, ack_n, rej_q, rej_n, auto_q, auto_n;
    logic   tie_q, tie_n, winner_q, winner_n;

    logic       tmr_reload, tmr_enable, timeout;
    logic       has_empty, cell_occ, wr_en;
    logic [3:0] first_idx, wr_idx;

    ttt_turn_timer #(
        .CYCLES_PER_SEC(CYCLES_PER_SEC),
        .TURN_SECONDS  (TURN_SECONDS)
    ) u_timer (
        .clk      (clk_i),
        .rst      (rst_i),
        .reload   (tmr_reload),
        .enable   (tmr_enable),
        .secs_left(secs_left_o),
        .timeout  (timeout)
    );

    // Lowest-index empty cell, used as the forced move on timeout.
    always_comb begin
        has_empty = 1'b0;
        first_idx = '0;
        for (int i = BOARD_CELLS - 1; i >= 0; i--) begin
            if (!board_q[i][1]) begin
                has_empty = 1'b1;
                first_idx = 4'(i);
            end
        end
    end

    always_comb begin
        cell_occ = 1'b0;
        for (int i = 0; i < BOARD_CELLS; i++) begin
            if (move_pos_i == 4'(i)) cell_occ = board_q[i][1];
        end
    end

    always_comb begin
        state_n    = state_q;
        board_n    = board_q;
        player_n   = player_q;
        ack_n      = 1'b0;
        rej_n      = 1'b0;
        auto_n     = 1'b0;
        tie_n      = tie_q;
        winner_n   = winner_q;
        tmr_reload = 1'b0;
        tmr_enable = 1'b0;
        wr_en      = 1'b0;
        wr_idx     = '0;

        case (state_q)
            IDLE: begin
                tmr_reload = 1'b1;
                if (start_i) begin
                    board_n  = {BOARD_CELLS{CELL_EMPTY}};
                    player_n = 1'b0;
                    state_n  = WAIT_MOVE;
                end
            end
            WAIT_MOVE: begin
                tmr_enable = 1'b1;
                if (move_valid_i && (move_pos_i <= 4'd8) && !cell_occ) begin
                    wr_en   = 1'b1;
                    wr_idx  = move_pos_i;
                    ack_n   = 1'b1;
                    state_n = CHECK;
                end else begin
                    rej_n = move_valid_i;
                    if (timeout) begin
                        wr_en   = has_empty;
                        wr_idx  = first_idx;
                        ack_n   = has_empty;
                        auto_n  = has_empty;
                        state_n = CHECK;
                    end
                end
            end
            CHECK: begin
                if (game_end_i) begin
                    tie_n    = tie_i;
                    winner_n = winner_i & ~tie_i;
                    state_n  = GAME_OVER;
                end else begin
                    player_n   = ~player_q;
                    tmr_reload = 1'b1;
                    state_n    = WAIT_MOVE;
                end
            end
            GAME_OVER: begin
                if (start_i) begin
                    board_n    = {BOARD_CELLS{CELL_EMPTY}};
                    player_n   = 1'b0;
                    tie_n      = 1'b0;
                    winner_n   = 1'b0;
                    tmr_reload = 1'b1;
                    state_n    = WAIT_MOVE;
                end
            end
            default: state_n = IDLE;
        endcase

        for (int i = 0; i < BOARD_CELLS; i++) begin
            if (wr_en && (wr_idx == 4'(i))) board_n[i] = player_q ? CELL_P1 : CELL_P0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            board_q  <= {BOARD_CELLS{CELL_EMPTY}};
            player_q <= 1'b0;
            ack_q    <= 1'b0;
            rej_q    <= 1'b0;
            auto_q   <= 1'b0;
            tie_q    <= 1'b0;
            winner_q <= 1'b0;
        end else begin
            state_q  <= state_n;
            board_q  <= board_n;
            player_q <= player_n;
            ack_q    <= ack_n;
            rej_q    <= rej_n;
            auto_q   <= auto_n;
            tie_q    <= tie_n;
            winner_q <= winner_n;
        end
    end

    assign board_o       = board_q;
    assign player_o      = player_q;
    assign move_ack_o    = ack_q;
    assign move_reject_o = rej_q;
    assign auto_move_o   = auto_q;
    assign game_over_o   = (state_q == GAME_OVER);
    assign tie_o         = tie_q;
    assign winner_o      = winner_q;

endmodule

// File: tb/tb_ttt_turn_controller.sv
// Directed bench for ttt_turn_controller with a behavioural game-end detector.
module tb_ttt_turn_controller;

    logic            clk = 1'b0;
    logic            rst, start, move_valid;
    logic [3:0]      move_pos;
    logic            game_end, tie_in, winner_in;
    logic [8:0][1:0] board;
    logic            player, ack, reject, auto_mv, game_over, tie, winner;
    logic [3:0]      secs;

    int n_cmp  = 0;
    int n_fail = 0;

    ttt_turn_controller #(.CYCLES_PER_SEC(4), .TURN_SECONDS(2)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .move_valid_i(move_valid), .move_pos_i(move_pos),
        .game_end_i(game_end), .tie_i(tie_in), .winner_i(winner_in),
        .board_o(board), .player_o(player), .move_ack_o(ack),
        .move_reject_o(reject), .auto_move_o(auto_mv), .secs_left_o(secs),
        .game_over_o(game_over), .tie_o(tie), .winner_o(winner)
    );

    always #5 clk = ~clk;

    // Reference detector: combinational on the board, as the real one is.
    int   lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                           '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    logic det_win, det_wid, det_full;
    always_comb begin
        det_win  = 1'b0;
        det_wid  = 1'b0;
        det_full = 1'b1;
        for (int i = 0; i < 9; i++) if (!board[i][1]) det_full = 1'b0;
        for (int l = 0; l < 8; l++) begin
            if (board[lines[l][0]][1] && board[lines[l][0]] == board[lines[l][1]] &&
                board[lines[l][0]] == board[lines[l][2]]) begin
                det_win = 1'b1;
                det_wid = board[lines[l][0]][0];
            end
        end
        game_end  = det_win | det_full;
        tie_in    = det_full & ~det_win;
        winner_in = det_wid;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_game;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic press(input logic [3:0] pos);
        move_valid = 1'b1;
        move_pos   = pos;
        tick();
        move_valid = 1'b0;
    endtask

    task automatic test_reset;
        n_cmp++; if (board !== '0) begin n_fail++; $display("FAIL reset_board: got %h want 0", board); end
        n_cmp++; if ({player, ack, reject, auto_mv} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {player, ack, reject, auto_mv}); end
        n_cmp++; if (secs !== 4'd2) begin n_fail++; $display("FAIL reset_secs: got %0d want 2", secs); end
        n_cmp++; if ({game_over, tie, winner} !== 3'b0) begin n_fail++; $display("FAIL reset_result: got %b want 000", {game_over, tie, winner}); end
    endtask

    task automatic test_win_p0;
        logic [3:0]      seq [5] = '{0, 3, 1, 4, 2};
        logic [8:0][1:0] exp_b;
        start_game();
        for (int k = 0; k < 5; k++) begin
            press(seq[k]);
            n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL win0_ack%0d: got %b want 1", k, ack); end
            if (k == 4) begin
                n_cmp++; if (game_over !== 1'b0) begin n_fail++; $display("FAIL win0_early_over: got %b want 0", game_over); end
            end
            tick();
        end
        exp_b = '0; exp_b[0] = 2'b10; exp_b[1] = 2'b10; exp_b[2] = 2'b10; exp_b[3] = 2'b11; exp_b[4] = 2'b11;
        n_cmp++; if (board !== exp_b) begin n_fail++; $display("FAIL win0_board: got %h want %h", board, exp_b); end
        n_cmp++; if ({game_over, tie, winner} !== 3'b100) begin n_fail++; $display("FAIL win0_result: got %b want 100", {game_over, tie, winner}); end
    endtask

    task automatic test_win_p1;
        logic [3:0]      seq [6] = '{0, 3, 1, 4, 8, 5};
        start_game();
        n_cmp++; if ({board, player, game_over, tie, winner} !== '0) begin n_fail++; $display("FAIL restart_clear: got %h want 0", {board, player, game_over, tie, winner}); end
        n_cmp++; if (secs !== 4'd2) begin n_fail++; $display("FAIL restart_secs: got %0d want 2", secs); end
        for (int k = 0; k < 6; k++) begin
            press(seq[k]);
            tick();
        end
        n_cmp++; if ({game_over, tie, winner} !== 3'b101) begin n_fail++; $display("FAIL win1_result: got %b want 101", {game_over, tie, winner}); end
    endtask

    task automatic test_reject;
        logic [8:0][1:0] exp_b;
        start_game();
        press(4);
        tick();
        n_cmp++; if (player !== 1'b1) begin n_fail++; $display("FAIL rej_turn: got %b want 1", player); end
        exp_b = '0; exp_b[4] = 2'b10;
        press(4);
        n_cmp++; if ({reject, ack} !== 2'b10) begin n_fail++; $display("FAIL rej_occ: got %b want 10", {reject, ack}); end
        n_cmp++; if (board !== exp_b || player !== 1'b1) begin n_fail++; $display("FAIL rej_occ_state: got %h/%b want %h/1", board, player, exp_b); end
        press(9);
        n_cmp++; if ({reject, ack} !== 2'b10) begin n_fail++; $display("FAIL rej_pos9: got %b want 10", {reject, ack}); end
        press(15);
        n_cmp++; if ({reject, ack} !== 2'b10 || board !== exp_b || player !== 1'b1) begin n_fail++; $display("FAIL rej_pos15: got %b %h %b want 10 %h 1", {reject, ack}, board, player, exp_b); end
        tick();
        n_cmp++; if (secs !== 4'd1 || reject !== 1'b0) begin n_fail++; $display("FAIL rej_timer: got secs %0d rej %b want 1 0", secs, reject); end
    endtask

    task automatic test_timeout;
        logic [8:0][1:0] exp_b;
        rst = 1'b1; tick(); rst = 1'b0;
        start_game();
        repeat (4) tick();
        n_cmp++; if (secs !== 4'd1) begin n_fail++; $display("FAIL to_secs: got %0d want 1", secs); end
        repeat (3) tick();
        n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL to_early: got %b want 0", ack); end
        tick();
        exp_b = '0; exp_b[0] = 2'b10;
        n_cmp++; if ({ack, auto_mv} !== 2'b11 || board !== exp_b) begin n_fail++; $display("FAIL to_auto0: got %b %h want 11 %h", {ack, auto_mv}, board, exp_b); end
        tick();
        n_cmp++; if (player !== 1'b1 || secs !== 4'd2) begin n_fail++; $display("FAIL to_next: got %b %0d want 1 2", player, secs); end
        repeat (8) tick();
        exp_b[1] = 2'b11;
        n_cmp++; if ({ack, auto_mv} !== 2'b11 || board !== exp_b) begin n_fail++; $display("FAIL to_auto1: got %b %h want 11 %h", {ack, auto_mv}, board, exp_b); end
        tick();
    endtask

    task automatic test_simultaneous;
        logic [8:0][1:0] exp_b;
        repeat (7) tick();
        press(8);
        exp_b = '0; exp_b[0] = 2'b10; exp_b[1] = 2'b11; exp_b[8] = 2'b10;
        n_cmp++; if ({ack, auto_mv, reject} !== 3'b100 || board !== exp_b) begin n_fail++; $display("FAIL sim_legal: got %b %h want 100 %h", {ack, auto_mv, reject}, board, exp_b); end
        tick();
        repeat (7) tick();
        press(8);
        exp_b[2] = 2'b11;
        n_cmp++; if ({ack, auto_mv, reject} !== 3'b111 || board !== exp_b) begin n_fail++; $display("FAIL sim_illegal: got %b %h want 111 %h", {ack, auto_mv, reject}, board, exp_b); end
        tick();
        n_cmp++; if (player !== 1'b0 || game_over !== 1'b0) begin n_fail++; $display("FAIL sim_next: got %b %b want 0 0", player, game_over); end
    endtask

    task automatic test_tie;
        logic [3:0]      seq [9] = '{0, 4, 8, 1, 7, 6, 2, 5, 3};
        logic [8:0][1:0] exp_b;
        rst = 1'b1; tick(); rst = 1'b0;
        start_game();
        for (int k = 0; k < 9; k++) begin
            press(seq[k]);
            n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL tie_ack%0d: got %b want 1", k, ack); end
            tick();
        end
        exp_b = {2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b10, 2'b10, 2'b11, 2'b10};
        n_cmp++; if (board !== exp_b) begin n_fail++; $display("FAIL tie_board: got %h want %h", board, exp_b); end
        n_cmp++; if ({game_over, tie, winner} !== 3'b110) begin n_fail++; $display("FAIL tie_result: got %b want 110", {game_over, tie, winner}); end
        press(0);
        repeat (10) tick();
        n_cmp++; if ({ack, reject, game_over, tie} !== 4'b0011 || board !== exp_b) begin n_fail++; $display("FAIL over_frozen: got %b %h want 0011 %h", {ack, reject, game_over, tie}, board, exp_b); end
    endtask

    task automatic test_midgame_reset;
        logic [8:0][1:0] exp_b;
        start_game();
        n_cmp++; if ({board, player, game_over, tie} !== '0 || secs !== 4'd2) begin n_fail++; $display("FAIL over_start: got %h %0d want 0 2", {board, player, game_over, tie}, secs); end
        press(0); tick();
        press(1); tick();
        press(2); tick();
        start_game();
        exp_b = '0; exp_b[0] = 2'b10; exp_b[1] = 2'b11; exp_b[2] = 2'b10;
        n_cmp++; if (board !== exp_b || player !== 1'b1) begin n_fail++; $display("FAIL start_in_wait: got %h %b want %h 1", board, player, exp_b); end
        rst = 1'b1; tick(); rst = 1'b0;
        n_cmp++; if ({board, player, game_over} !== '0 || secs !== 4'd2) begin n_fail++; $display("FAIL mid_reset: got %h %0d want 0 2", {board, player, game_over}, secs); end
        press(5);
        n_cmp++; if ({ack, reject} !== 2'b00 || board !== '0) begin n_fail++; $display("FAIL idle_ignore: got %b %h want 00 0", {ack, reject}, board); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; move_valid = 1'b0; move_pos = '0;
        tick(); tick();
        rst = 1'b0;
        test_reset();
        test_win_p0();
        test_win_p1();
        test_reject();
        test_timeout();
        test_simultaneous();
        test_tie();
        test_midgame_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ttt_turn_controller.md
Name: ttt_turn_controller

Overview:
- Sequential game controller sitting directly upstream of the game-end detector.
- Owns the 9-cell board register and drives it to the detector every cycle.
- Accepts player moves, alternates turns, and auto-plays a move when the per-turn timer expires.
- Consumes the detector's end/tie/winner flags to freeze the game and report the result.

Parameters:
- CYCLES_PER_SEC, 50_000_000, clock cycles per timer second (benches use 4).
- TURN_SECONDS, 10, seconds allowed per turn; range 1..15.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  begin a new game; honoured in IDLE and GAME_OVER only.
- move_valid_i  input  1  single-cycle move request.
- move_pos_i  input  4  cell index 0..8; row-major, 0 = top-left.
- game_end_i  input  1  from detector.
- tie_i  input  1  from detector.
- winner_i  input  1  from detector; player id of the winning line.
- board_o  output  [8:0][1:0]  to detector. Cell encoding: 2'b00 empty, 2'b10 player 0, 2'b11 player 1; bit[1] = occupied.
- player_o  output  1  player whose turn it is.
- move_ack_o  output  1  1-cycle pulse; move written (user or auto).
- move_reject_o  output  1  1-cycle pulse; illegal request.
- auto_move_o  output  1  1-cycle pulse, coincident with move_ack_o, when the timer forced the move.
- secs_left_o  output  4  seconds remaining in the current turn.
- game_over_o  output  1  high in GAME_OVER.
- tie_o  output  1  registered result, valid while game_over_o is high.
- winner_o  output  1  registered result, valid while game_over_o is high.

Behaviour:
- Reset values:
  - State IDLE; board all 2'b00; player_o = 0.
  - All pulse outputs 0; secs_left_o = TURN_SECONDS.
  - game_over_o, tie_o, winner_o = 0.
- IDLE:
  - start_i -> WAIT_MOVE.
  - Board cleared, player_o = 0, timer reloaded.
- WAIT_MOVE, request handling:
  - move_valid_i is legal if move_pos_i <= 8 and that cell is empty.
  - Legal request: on the next clock edge write {1'b1, player_o} to the cell, pulse move_ack_o, go to CHECK.
  - Illegal request (pos > 8 or occupied): pulse move_reject_o. Board, player and timer are unchanged.
- WAIT_MOVE, timer:
  - Prescaler counts 0..CYCLES_PER_SEC-1.
  - On wrap, secs_left_o decrements.
  - When secs_left_o == 1 and the prescaler wraps, the timeout fires.
- WAIT_MOVE, auto move:
  - On timeout, write the lowest-index empty cell for player_o.
  - Pulse move_ack_o and auto_move_o; go to CHECK.
  - secs_left_o never shows 0 in WAIT_MOVE.
- Simultaneous legal request and timeout: the user move wins and auto_move_o stays 0.
- Simultaneous illegal request and timeout: auto move executes and move_reject_o pulses in the same cycle.
- CHECK (exactly 1 cycle): the detector is combinational on board_o, so its flags are sampled here.
  - game_end_i = 1 -> GAME_OVER; latch tie_o <= tie_i, winner_o <= winner_i & ~tie_i.
  - Otherwise -> WAIT_MOVE; toggle player_o and reload the timer (secs_left_o = TURN_SECONDS, prescaler 0).
  - move_valid_i is ignored (no ack, no reject).
- Latency: request at cycle N; board updated at N+1; result or next turn visible at N+2.
- GAME_OVER:
  - Board frozen, timer halted, moves ignored.
  - start_i clears the board, tie_o, winner_o and game_over_o, sets player_o = 0, reloads the timer, and enters WAIT_MOVE.
- start_i is ignored in WAIT_MOVE and CHECK.
- rst_i has priority in every state. Mid-game reset returns all reset values on the next edge.
- A full board without a win must be reported by the detector as a tie. The controller never waits on a full board, because CHECK always follows the 9th write.

Decomposition:
- Package ttt_pkg holds:
  - cell_t 2-bit encoding constants CELL_EMPTY = 2'b00, CELL_P0 = 2'b10, CELL_P1 = 2'b11;
  - BOARD_CELLS = 9;
  - board_t packed [8:0][1:0];
  - state enum {IDLE, WAIT_MOVE, CHECK, GAME_OVER}.
- Sub-module ttt_turn_timer: prescaler plus seconds down-counter.
  - Inputs: reload and enable.
  - Outputs: secs_left and a timeout pulse.
- First-empty-cell finder stays in this module as a priority encoder.

Test Plan:
- Reset then start_i; moves 0,3,1,4,2 -> acks each, board[0..2] = 2'b10, game_over_o = 1, winner_o = 0, tie_o = 0 two cycles after the 5th request.
- Move to cell 4, then a second request to cell 4 in the next WAIT_MOVE -> move_reject_o pulse, player_o still 1, board unchanged.
- move_pos_i = 9 or 15 -> move_reject_o, no state change.
- CYCLES_PER_SEC = 4, TURN_SECONDS = 2, no input -> after 8 cycles auto_move_o + move_ack_o, cell 0 = 2'b10. Next timeout fills cell 1 = 2'b11.
- Legal move on the exact timeout cycle -> only the user cell written, auto_move_o = 0. Sequence 0,4,8,1,7,6,2,5,3 -> tie_o = 1, winner_o = 0.
- rst_i asserted in WAIT_MOVE with 3 cells filled -> next cycle board all 2'b00, state IDLE. start_i in GAME_OVER -> clean board, player_o = 0, secs_left_o = TURN_SECONDS.
